// File: rtl/encoder_trig_ctrl_pkg.sv
// Shared encodings for the encoder-position trigger controller.
// FSM states, abort reasons and the wrap-safe position comparison.
package encoder_trig_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETTLE   = 3'd1;
    localparam logic [2:0] ST_WAIT_POS = 3'd2;
    localparam logic [2:0] ST_REQ      = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;

    localparam logic [1:0] ABORT_NONE = 2'd0;
    localparam logic [1:0] ABORT_STOP = 2'd1;
    localparam logic [1:0] ABORT_ENC  = 2'd2;
    localparam logic [1:0] ABORT_OVR  = 2'd3;

    // True when pos is at or past target, judged by the sign of the modular
    // difference so the comparison survives counter wrap.
    function automatic logic pos_reached(input logic [31:0] pos, input logic [31:0] target);
        logic [31:0] diff;
        diff = pos - target;
        return ~diff[31];
    endfunction

endpackage

// File: rtl/encoder_trig_ctrl_pos_cmp.sv
// Registered "pos reached target" comparator, signed and wrap-safe.
// One cycle of latency; result reflects the operands of the previous cycle.
module pos_cmp
    import encoder_trig_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pos,
    input  logic [31:0] target,
    output logic        reached_q
);

    logic reached_d;

    always_comb begin
        reached_d = pos_reached(pos, target);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reached_q <= 1'b0;
        end else begin
            reached_q <= reached_d;
        end
    end

endmodule

// File: rtl/encoder_trig_ctrl.sv
// Scans the encoder position and issues num_trig acquisition triggers spaced
// by step, with settle delay, overrun detection and abort reporting.
module encoder_trig_ctrl
    import encoder_trig_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] start_pos,
    input  logic [15:0] step,
    input  logic [15:0] num_trig,
    input  logic [31:0] enc_cnt,
    input  logic        enc_err,
    input  logic        trig_ack,
    output logic        capture_start,
    output logic        trig_req,
    output logic [15:0] trig_idx,
    output logic        busy,
    output logic        done_p,
    output logic [1:0]  abort_code
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] settle_cnt_q, settle_cnt_d;
    logic [31:0]   next_pos_q, next_pos_d;
    logic [15:0]   step_q, step_d;
    logic [15:0]   num_q, num_d;
    logic [15:0]   trig_idx_q, trig_idx_d;
    logic [1:0]    abort_q, abort_d;
    logic          capture_q, capture_d;
    logic          trig_req_q, trig_req_d;
    logic          done_q, done_d;
    logic          trig_hit_q, ovr_hit_q, last_trig;
    logic [31:0]   ovr_pos;

    // Comparators look at next_pos_d so their registered result already
    // refers to the new target in the first cycle after it changes.
    assign ovr_pos = next_pos_d + {16'd0, step_q};

    pos_cmp u_trig_cmp (
        .clk       (clk),
        .rst       (rst),
        .pos       (enc_cnt),
        .target    (next_pos_d),
        .reached_q (trig_hit_q)
    );

    pos_cmp u_ovr_cmp (
        .clk       (clk),
        .rst       (rst),
        .pos       (enc_cnt),
        .target    (ovr_pos),
        .reached_q (ovr_hit_q)
    );

    assign last_trig = (trig_idx_q == num_q - 16'd1);

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        next_pos_d   = next_pos_q;
        step_d       = step_q;
        num_d        = num_q;
        trig_idx_d   = trig_idx_q;
        abort_d      = abort_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                    next_pos_d   = start_pos;
                    step_d       = step;
                    num_d        = num_trig;
                    trig_idx_d   = 16'd0;
                    abort_d      = ABORT_NONE;
                end
            end
            ST_SETTLE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    abort_d = ABORT_STOP;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    settle_cnt_d = '0;
                    state_d      = (num_q == 16'd0) ? ST_FINISH : ST_WAIT_POS;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_WAIT_POS: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    abort_d = ABORT_STOP;
                end else if (enc_err) begin
                    state_d = ST_IDLE;
                    abort_d = ABORT_ENC;
                end else if (trig_hit_q) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack always completes its handshake, even when the scan aborts.
                if (trig_ack) begin
                    next_pos_d = next_pos_q + {16'd0, step_q};
                    trig_idx_d = last_trig ? trig_idx_q : trig_idx_q + 16'd1;
                    state_d    = last_trig ? ST_FINISH : ST_WAIT_POS;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                    abort_d = ABORT_STOP;
                end else if (enc_err) begin
                    state_d = ST_IDLE;
                    abort_d = ABORT_ENC;
                end else if (!trig_ack && ovr_hit_q && step_q != 16'd0) begin
                    // With step==0 every trigger shares one position; nothing can be overrun.
                    state_d = ST_IDLE;
                    abort_d = ABORT_OVR;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                if (stop) begin
                    abort_d = ABORT_STOP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        capture_d  = (state_d == ST_SETTLE) || (state_d == ST_WAIT_POS) || (state_d == ST_REQ);
        trig_req_d = (state_d == ST_REQ);
        done_d     = (state_q == ST_FINISH) && !stop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            next_pos_q   <= 32'd0;
            step_q       <= 16'd0;
            num_q        <= 16'd0;
            trig_idx_q   <= 16'd0;
            abort_q      <= ABORT_NONE;
            capture_q    <= 1'b0;
            trig_req_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            next_pos_q   <= next_pos_d;
            step_q       <= step_d;
            num_q        <= num_d;
            trig_idx_q   <= trig_idx_d;
            abort_q      <= abort_d;
            capture_q    <= capture_d;
            trig_req_q   <= trig_req_d;
            done_q       <= done_d;
        end
    end

    assign capture_start = capture_q;
    assign trig_req      = trig_req_q;
    assign trig_idx      = trig_idx_q;
    assign busy          = (state_q != ST_IDLE);
    assign done_p        = done_q;
    assign abort_code    = abort_q;

endmodule
